// File: rtl/chr_bus_arbiter.sv
// CHR memory port arbiter: the PPU always owns the bus; an auxiliary requester gets idle gaps via req/ack with abort-and-retry.
// Optional stall statistics are built when CHR_ARB_STAT_EN is defined.
module chr_bus_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int AUX_WAIT  = 2,
  parameter int PPU_GUARD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ppu_req,
  input  logic              ppu_we,
  input  logic [ADDR_W-1:0] ppu_addr,
  input  logic [7:0]        ppu_dati,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [7:0]        aux_dati,
  output logic              aux_ack,
  output logic [7:0]        aux_dato,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dato,
  output logic              mem_ce,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [15:0]       aux_stall
);

  typedef enum logic [2:0] {IDLE, PPU, GUARD, AUX, DONE} state_t;

  localparam int CW = $clog2(AUX_WAIT) + 1;
  localparam int GW = $clog2(PPU_GUARD) + 1;
  localparam int GUARD_LAST_I = (PPU_GUARD > 0) ? PPU_GUARD - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST   = CW'(AUX_WAIT - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_LAST_I);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [GW-1:0] gcnt, gcnt_nx;
  logic          aux_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      gcnt  <= gcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    gcnt_nx  = gcnt;
    aux_done = 1'b0;
    case (state)
      IDLE: begin
        if (ppu_req) begin
          state_nx = PPU;
        end else if (aux_req) begin
          state_nx = AUX;
          cnt_nx   = '0;
        end
      end
      PPU: begin
        if (!ppu_req) begin
          if (PPU_GUARD == 0) begin
            state_nx = IDLE;
          end else begin
            state_nx = GUARD;
            gcnt_nx  = '0;
          end
        end
      end
      GUARD: begin
        if (ppu_req) begin
          state_nx = PPU;
        end else if (gcnt == GUARD_LAST) begin
          state_nx = IDLE;
        end else begin
          gcnt_nx = gcnt + 1'b1;
        end
      end
      AUX: begin
        // A preempted access keeps aux_req pending and restarts from cnt=0 once the PPU leaves.
        if (ppu_req) begin
          state_nx = PPU;
          cnt_nx   = '0;
        end else if (!aux_req) begin
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nx = DONE;
          aux_done = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aux_dato <= '0;
    end else if (aux_done && !aux_we) begin
      aux_dato <= mem_din;
    end
  end

  assign aux_ack = (state == DONE);

  // The PPU overrides the bus combinationally, so an aborted aux write never reaches mem_we.
  always_comb begin
    mem_addr = ppu_addr;
    mem_dato = ppu_dati;
    mem_ce   = 1'b0;
    mem_oe   = 1'b0;
    mem_we   = 1'b0;
    if (ppu_req) begin
      mem_ce = 1'b1;
      mem_oe = !ppu_we;
      mem_we = ppu_we;
    end else if (state == AUX) begin
      mem_addr = aux_addr;
      mem_dato = aux_dati;
      mem_ce   = 1'b1;
      mem_oe   = !aux_we;
      mem_we   = aux_we && (cnt == CNT_LAST);
    end
  end

`ifdef CHR_ARB_STAT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (aux_req && (state != AUX) && (state != DONE) && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign aux_stall = stall_q;
`else
  assign aux_stall = 16'h0000;
`endif

endmodule

// File: tb/tb_chr_bus_arbiter.sv
// Directed bench for chr_bus_arbiter: a per-cycle vector table plus hand-written reset and statistics sequences.
module tb_chr_bus_arbiter;

  localparam int ADDR_W = 18;
  localparam logic [ADDR_W-1:0] PPU_ADDR = 18'h00AAA;
  localparam logic [ADDR_W-1:0] AUX_ADDR = 18'h01234;
  localparam logic [7:0] PPU_DATI = 8'h11;
  localparam logic [7:0] AUX_DATI = 8'h3C;
  localparam int NVEC = 39;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ppu_req, ppu_we, aux_req, aux_we;
  logic [ADDR_W-1:0] ppu_addr, aux_addr, mem_addr;
  logic [7:0]        ppu_dati, aux_dati, aux_dato, mem_din, mem_dato;
  logic              aux_ack, mem_ce, mem_oe, mem_we;
  logic [15:0]       aux_stall;

  int n_compared = 0;
  int n_mismatched = 0;
  int stall_exp = 0;

  // in = {ppu_req, ppu_we, aux_req, aux_we}; out = {ce, oe, we, ack, bus_from_aux, state_is_aux_or_done}
  typedef struct {
    logic [3:0] in;
    logic [7:0] din;
    logic [5:0] out;
    logic [7:0] dato;
  } vec_t;

  vec_t vecs[NVEC];

  chr_bus_arbiter #(.ADDR_W(ADDR_W), .AUX_WAIT(2), .PPU_GUARD(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_dati(ppu_dati),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_dati(aux_dati),
    .aux_ack(aux_ack), .aux_dato(aux_dato), .mem_din(mem_din),
    .mem_addr(mem_addr), .mem_dato(mem_dato), .mem_ce(mem_ce), .mem_oe(mem_oe),
    .mem_we(mem_we), .aux_stall(aux_stall)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic [3:0] in, input logic [7:0] din,
                               input logic [5:0] out, input logic [7:0] dato);
    vec_t v;
    v.in = in; v.din = din; v.out = out; v.dato = dato;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    {ppu_req, ppu_we, aux_req, aux_we} = v.in;
    mem_din = v.din;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    check_val({tag, ".mem_ce"}, 32'(mem_ce), 32'(v.out[5]));
    check_val({tag, ".mem_oe"}, 32'(mem_oe), 32'(v.out[4]));
    check_val({tag, ".mem_we"}, 32'(mem_we), 32'(v.out[3]));
    check_val({tag, ".aux_ack"}, 32'(aux_ack), 32'(v.out[2]));
    check_val({tag, ".aux_dato"}, 32'(aux_dato), 32'(v.dato));
    check_val({tag, ".aux_stall"}, 32'(aux_stall), 32'(stall_exp));
    if (v.out[5]) begin
      check_val({tag, ".mem_addr"}, 32'(mem_addr), v.out[1] ? 32'(AUX_ADDR) : 32'(PPU_ADDR));
      check_val({tag, ".mem_dato"}, 32'(mem_dato), v.out[1] ? 32'(AUX_DATI) : 32'(PPU_DATI));
    end
  endtask

  initial begin
    // Uncontended read, uncontended write
    vecs[0]  = mkv(4'b0000, 8'h00, 6'b000000, 8'h00);
    vecs[1]  = mkv(4'b0010, 8'hA5, 6'b000000, 8'h00);
    vecs[2]  = mkv(4'b0010, 8'hA5, 6'b110011, 8'h00);
    vecs[3]  = mkv(4'b0010, 8'hA5, 6'b110011, 8'h00);
    vecs[4]  = mkv(4'b0010, 8'hA5, 6'b000101, 8'hA5);
    vecs[5]  = mkv(4'b0000, 8'hA5, 6'b000000, 8'hA5);
    vecs[6]  = mkv(4'b0011, 8'h5A, 6'b000000, 8'hA5);
    vecs[7]  = mkv(4'b0011, 8'h5A, 6'b100011, 8'hA5);
    vecs[8]  = mkv(4'b0011, 8'h5A, 6'b101011, 8'hA5);
    vecs[9]  = mkv(4'b0011, 8'h5A, 6'b000101, 8'hA5);
    vecs[10] = mkv(4'b0001, 8'h5A, 6'b000000, 8'hA5);
    // Simultaneous request (PPU wins), guard, then aux write preempted in its first cycle and retried
    vecs[11] = mkv(4'b1011, 8'h5A, 6'b110000, 8'hA5);
    vecs[12] = mkv(4'b0011, 8'h5A, 6'b000000, 8'hA5);
    vecs[13] = mkv(4'b0011, 8'h5A, 6'b000000, 8'hA5);
    vecs[14] = mkv(4'b0011, 8'h5A, 6'b000000, 8'hA5);
    vecs[15] = mkv(4'b1111, 8'h5A, 6'b101001, 8'hA5);
    vecs[16] = mkv(4'b0011, 8'h5A, 6'b000000, 8'hA5);
    vecs[17] = mkv(4'b0011, 8'h5A, 6'b000000, 8'hA5);
    vecs[18] = mkv(4'b0011, 8'h5A, 6'b000000, 8'hA5);
    vecs[19] = mkv(4'b0011, 8'h5A, 6'b100011, 8'hA5);
    vecs[20] = mkv(4'b0011, 8'h5A, 6'b101011, 8'hA5);
    vecs[21] = mkv(4'b0011, 8'h5A, 6'b000101, 8'hA5);
    vecs[22] = mkv(4'b0000, 8'h5A, 6'b000000, 8'hA5);
    // Cancel in AUX
    vecs[23] = mkv(4'b0010, 8'h77, 6'b000000, 8'hA5);
    vecs[24] = mkv(4'b0000, 8'h77, 6'b110011, 8'hA5);
    vecs[25] = mkv(4'b0000, 8'h77, 6'b000000, 8'hA5);
    // Read preempted in its last cycle, PPU re-entering from GUARD, then retry
    vecs[26] = mkv(4'b0010, 8'h42, 6'b000000, 8'hA5);
    vecs[27] = mkv(4'b0010, 8'h42, 6'b110011, 8'hA5);
    vecs[28] = mkv(4'b1010, 8'h42, 6'b110001, 8'hA5);
    vecs[29] = mkv(4'b1010, 8'h42, 6'b110000, 8'hA5);
    vecs[30] = mkv(4'b0010, 8'h42, 6'b000000, 8'hA5);
    vecs[31] = mkv(4'b1010, 8'h42, 6'b110000, 8'hA5);
    vecs[32] = mkv(4'b0010, 8'h42, 6'b000000, 8'hA5);
    vecs[33] = mkv(4'b0010, 8'h42, 6'b000000, 8'hA5);
    vecs[34] = mkv(4'b0010, 8'h42, 6'b000000, 8'hA5);
    vecs[35] = mkv(4'b0010, 8'h42, 6'b110011, 8'hA5);
    vecs[36] = mkv(4'b0010, 8'h42, 6'b110011, 8'hA5);
    vecs[37] = mkv(4'b0010, 8'h42, 6'b000101, 8'h42);
    vecs[38] = mkv(4'b0000, 8'h42, 6'b000000, 8'h42);

    rst_n = 1'b0;
    ppu_req = 1'b0; ppu_we = 1'b0; aux_req = 1'b0; aux_we = 1'b0;
    ppu_addr = PPU_ADDR; ppu_dati = PPU_DATI;
    aux_addr = AUX_ADDR; aux_dati = AUX_DATI;
    mem_din = 8'h00;

    repeat (2) tick();
    check_val("reset.aux_ack", 32'(aux_ack), 32'd0);
    check_val("reset.aux_dato", 32'(aux_dato), 32'd0);
    check_val("reset.aux_stall", 32'(aux_stall), 32'd0);
    check_val("reset.mem_ce", 32'(mem_ce), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i], i);
      tick();
`ifdef CHR_ARB_STAT_EN
      if (vecs[i].in[1] && !vecs[i].out[0] && stall_exp < 16'hFFFF) stall_exp++;
`endif
    end

    // Reset pulsed in the write cycle of an aux write
    aux_req = 1'b1; aux_we = 1'b1;
    tick();
    tick();
    check_val("rstmid.pre_mem_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rstmid.mem_ce", 32'(mem_ce), 32'd0);
    check_val("rstmid.mem_we", 32'(mem_we), 32'd0);
    check_val("rstmid.aux_ack", 32'(aux_ack), 32'd0);
    check_val("rstmid.aux_dato", 32'(aux_dato), 32'd0);
    check_val("rstmid.aux_stall", 32'(aux_stall), 32'd0);
    aux_req = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rstmid.idle_ce", 32'(mem_ce), 32'd0);
    tick();
    aux_req = 1'b1; aux_we = 1'b0; mem_din = 8'h99;
    @(negedge clk);
    check_val("rstmid.c0_ce", 32'(mem_ce), 32'd0);
    tick();
    @(negedge clk);
    check_val("rstmid.c1_ce", 32'(mem_ce), 32'd1);
    tick();
    @(negedge clk);
    check_val("rstmid.c2_ce", 32'(mem_ce), 32'd1);
    check_val("rstmid.c2_ack", 32'(aux_ack), 32'd0);
    tick();
    @(negedge clk);
    check_val("rstmid.c3_ack", 32'(aux_ack), 32'd1);
    check_val("rstmid.c3_dato", 32'(aux_dato), 32'h99);
    tick();
    aux_req = 1'b0;
    tick();

`ifdef CHR_ARB_STAT_EN
    // Stall counting while the PPU holds the bus, then saturation
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    ppu_req = 1'b1;
    tick();
    aux_req = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check_val("stat.ten", 32'(aux_stall), 32'd10);
    check_val("stat.ppu_owns", 32'(mem_addr), 32'(PPU_ADDR));
    tick();
    repeat (65600) tick();
    @(negedge clk);
    check_val("stat.saturate", 32'(aux_stall), 32'hFFFF);
    tick();
    ppu_req = 1'b0; aux_req = 1'b0;
    repeat (3) tick();
    check_val("stat.hold", 32'(aux_stall), 32'hFFFF);
`else
    check_val("stat.tied_zero", 32'(aux_stall), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
